// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: address/word types, the fetch->decode
// bundle, FSM state constants and the default reset PC.
package fetch_pkg;

    typedef logic [63:0] word_t;
    typedef word_t       addr_t;
    typedef logic [31:0] u32;

    localparam addr_t PC_RESET_DEFAULT = 64'h8000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE = 2'd0;
    localparam fetch_state_t S_REQ  = 2'd1;
    localparam fetch_state_t S_BUF  = 2'd2;

    typedef struct packed {
        word_t pc;
        u32    raw_instr;
        logic  en;
    } fetch_data_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction bus between fetch (master) and instruction memory (slave).
// Ports: ireq_valid/ireq_addr (request), iresp_data_ok/iresp_data (response).
interface fetch_if;
    import fetch_pkg::*;

    logic  ireq_valid;
    addr_t ireq_addr;
    logic  iresp_data_ok;
    u32    iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry hold buffer for an instruction that decode could not take.
// Ports: clk, reset, load_i/clear_i/flush_i controls, data_i in, data_o/valid_o out.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic clear_i,
    input  logic flush_i,
    input  u32   data_i,
    output u32   data_o,
    output logic valid_o
);

    u32   data_q;
    logic valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, one outstanding bus request,
// zero-bubble delivery, stall hold buffer and redirect handling.
// Ports: clk, reset, stall, redirect_valid/redirect_pc, ibus (master), dataF.
module fetch
    import fetch_pkg::*;
#(
    parameter addr_t PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  addr_t       redirect_pc,
    fetch_if.master     ibus,
    output fetch_data_t dataF
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    addr_t        tgt_q, tgt_d;
    logic         drop_q, drop_d;

    logic skid_load, skid_clear, skid_flush;
    logic skid_valid;
    u32   skid_data;

    logic req;
    logic en;
    u32   instr;

    fetch_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .flush_i (skid_flush),
        .data_i  (ibus.iresp_data),
        .data_o  (skid_data),
        .valid_o (skid_valid)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        drop_d     = drop_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        skid_flush = 1'b0;
        req        = 1'b0;
        en         = 1'b0;
        instr      = '0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) pc_d = redirect_pc;
            end
            S_REQ: begin
                req = 1'b1;
                if (drop_q) begin
                    // Address must stay stable, so redirects only retarget.
                    if (redirect_valid) tgt_d = redirect_pc;
                    if (ibus.iresp_data_ok) begin
                        drop_d = 1'b0;
                        pc_d   = redirect_valid ? redirect_pc : tgt_q;
                    end
                end else if (redirect_valid) begin
                    if (ibus.iresp_data_ok) begin
                        pc_d = redirect_pc;
                    end else begin
                        drop_d = 1'b1;
                        tgt_d  = redirect_pc;
                    end
                end else if (ibus.iresp_data_ok) begin
                    en    = 1'b1;
                    instr = ibus.iresp_data;
                    if (stall) begin
                        skid_load = 1'b1;
                        state_d   = S_BUF;
                    end else begin
                        pc_d = pc_q + 64'd4;
                    end
                end
            end
            S_BUF: begin
                if (redirect_valid) begin
                    skid_flush = 1'b1;
                    pc_d       = redirect_pc;
                    state_d    = S_REQ;
                end else begin
                    en    = skid_valid;
                    instr = skid_data;
                    if (!stall) begin
                        skid_clear = 1'b1;
                        pc_d       = pc_q + 64'd4;
                        state_d    = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            tgt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            drop_q  <= drop_d;
        end
    end

    assign ibus.ireq_valid = req;
    assign ibus.ireq_addr  = pc_q;
    assign dataF.pc        = pc_q;
    assign dataF.raw_instr = instr;
    assign dataF.en        = en;

endmodule
